// File: rtl/char_vram_pkg.sv
// char_vram_pkg: shared defaults, clog2 helper and clear-engine states for the character VRAM
package char_vram_pkg;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 60;
  localparam int DW_DEF = 11;
  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/char_vram_dpram.sv
// char_vram_dpram: one write port, two registered read-first read ports, BRAM-mappable
module char_vram_dpram
  import char_vram_pkg::*;
#(
  parameter int DEPTH = COLS_DEF * ROWS_DEF,
  parameter int AW = clog2(DEPTH),
  parameter int DW = DW_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    dout_a <= mem[raddr_a];
    dout_b <= mem[raddr_b];
  end
endmodule

// File: rtl/char_vram_ctrl.sv
// char_vram_ctrl: character VRAM with CPU port, scrolled display port and clear-screen engine
module char_vram_ctrl
  import char_vram_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int DW = DW_DEF,
  localparam int DEPTH = COLS * ROWS,
  localparam int AW = clog2(DEPTH),
  localparam int SW = clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  input  logic          cpu_re,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_rvalid,
  output logic          cpu_ready,
  input  logic [AW-1:0] disp_addr,
  input  logic          disp_rdn,
  output logic [DW-1:0] disp_dout,
  input  logic          scroll_we,
  input  logic [SW-1:0] scroll_din,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_val,
  output logic          busy
);
  clr_state_t state;
  logic [AW-1:0] ptr, phys, wr_addr;
  logic [DW-1:0] fill, wr_data, ram_a, ram_b;
  logic [SW-1:0] scroll_row;
  logic ready_q, oor_q, disp_en_q, cpu_wr, cpu_rd, wr_en, last;
  assign busy = state == CLEAR;
  assign cpu_ready = ready_q & ~busy;
  assign cpu_wr = cpu_ready & cpu_we & ({1'b0, cpu_addr} < (AW+1)'(DEPTH));
  assign cpu_rd = cpu_ready & cpu_re & ~cpu_we;
  assign wr_en = busy | cpu_wr;
  assign wr_addr = busy ? ptr : cpu_addr;
  assign wr_data = busy ? fill : cpu_din;
  assign last = ptr == AW'(DEPTH - 1);
  assign phys = AW'((32'(disp_addr) + 32'(scroll_row) * 32'(COLS)) % 32'(DEPTH));
  // RAM output registers carry no reset, so zeroing is applied after them
  assign cpu_dout = (cpu_rvalid & ~oor_q) ? ram_a : '0;
  assign disp_dout = disp_en_q ? ram_b : '0;
  char_vram_dpram #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_ram (
    .clk(clk), .we(wr_en), .waddr(wr_addr), .wdata(wr_data),
    .raddr_a(cpu_addr), .raddr_b(phys), .dout_a(ram_a), .dout_b(ram_b)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ptr <= '0;
      fill <= '0;
      scroll_row <= '0;
      ready_q <= 1'b0;
      cpu_rvalid <= 1'b0;
      oor_q <= 1'b0;
      disp_en_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      cpu_rvalid <= cpu_rd;
      oor_q <= {1'b0, cpu_addr} >= (AW+1)'(DEPTH);
      disp_en_q <= ~disp_rdn;
      if (scroll_we && ({1'b0, scroll_din} < (SW+1)'(ROWS))) scroll_row <= scroll_din;
      if (state == IDLE && clr_start) begin
        state <= CLEAR;
        fill <= clr_val;
        ptr <= '0;
      end else if (busy) begin
        ptr <= last ? '0 : ptr + 1'b1;
        state <= last ? IDLE : CLEAR;
      end
    end
  end
endmodule

// File: doc/char_vram_ctrl.md
CHAR_VRAM_CTRL -- requirements
Module: char_vram_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per row.
REQ-002 SHALL have parameter ROWS, default 60, character rows.
REQ-003 SHALL have parameter DW, default 11, cell width (char code plus attributes).
REQ-004 SHALL derive localparams DEPTH = COLS*ROWS and AW = clog2(DEPTH), which is 13 at the defaults.
REQ-005 SHALL run on one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock for all state.
- rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL provide these CPU-side ports:
- cpu_addr  in  AW  cell address.
- cpu_din  in  DW  write data.
- cpu_we  in  1  write strobe.
- cpu_re  in  1  read strobe.
- cpu_dout  out  DW  read data.
- cpu_rvalid  out  1  one-cycle pulse, cpu_dout valid.
- cpu_ready  out  1  high when CPU requests are accepted.
REQ-007 SHALL provide these display-side ports:
- disp_addr  in  AW  logical cell address.
- disp_rdn  in  1  active-low read enable.
- disp_dout  out  DW  registered cell data.
REQ-008 SHALL provide these control ports:
- scroll_we  in  1  load strobe for scroll_row.
- scroll_din  in  clog2(ROWS)  new scroll row.
- clr_start  in  1  clear-screen request pulse.
- clr_val  in  DW  fill value.
- busy  out  1  clear engine active.

Function
REQ-009 SHALL hold DEPTH words of DW bits in a simple dual-port memory with one write port and two read ports (CPU, display).
REQ-010 CPU write: when cpu_we and cpu_ready are high at an edge, the memory SHALL store cpu_din at cpu_addr; addresses >= DEPTH are ignored.
REQ-011 CPU read: when cpu_re and cpu_ready are high (and cpu_we is low), cpu_dout SHALL show the word on the next edge and cpu_rvalid SHALL pulse for 1 cycle; cpu_we wins if both strobes are high; an out-of-range read returns 0 and still pulses cpu_rvalid.
REQ-012 Display read latency SHALL be 1 cycle: phys = (disp_addr + scroll_row*COLS) mod DEPTH, and disp_dout <= mem[phys]; when disp_rdn is high, disp_dout <= 0.
REQ-013 Same-address write and display read in the same cycle SHALL return the old data (read-first).
REQ-014 A scroll_we pulse SHALL load scroll_din into scroll_row, effective for display reads sampled on the next cycle; values >= ROWS are ignored and scroll_row is held.
REQ-015 Clear FSM SHALL have states IDLE and CLEAR: IDLE -> CLEAR on clr_start, with clr_val latched; in CLEAR, mem[ptr] <= latched value and ptr increments by 1 per cycle from 0; CLEAR -> IDLE after the write to ptr = DEPTH-1.
REQ-016 The clear SHALL take exactly DEPTH cycles; busy SHALL be high and cpu_ready low from the cycle after clr_start until IDLE is re-entered.
REQ-017 While busy, cpu_we and cpu_re SHALL be ignored: no write, no cpu_rvalid.
REQ-018 clr_start during CLEAR SHALL be ignored, and the clear SHALL not restart.
REQ-019 Display reads SHALL continue during CLEAR and return memory contents per REQ-013.
REQ-020 scroll_row SHALL be unaffected by the clear.

Reset
REQ-021 While rstn is low: cpu_dout = 0, cpu_rvalid = 0, disp_dout = 0, busy = 0, cpu_ready = 0, scroll_row = 0, FSM = IDLE, ptr = 0.
REQ-022 cpu_ready SHALL rise on the first edge after rstn deasserts.
REQ-023 Memory contents SHALL not be reset; a reset during CLEAR aborts the clear and leaves the memory partially filled.

Structure
REQ-024 Package char_vram_pkg SHALL hold the default COLS/ROWS/DW, the clog2 function and the FSM state enum (IDLE, CLEAR).
REQ-025 Sub-module char_vram_dpram SHALL hold the storage: one synchronous write port, two registered read ports, BRAM-mappable, optional init-file parameter.
REQ-026 The address translation, scroll register, CPU port and clear FSM SHALL reside in char_vram_ctrl.

Verification
REQ-027 Write 0x41 to addr 5, then read addr 5 -> cpu_dout = 0x41 one cycle after cpu_re, with cpu_rvalid high for 1 cycle.
REQ-028 Scroll: mem[80] = 0x7FF, scroll_din = 1, disp_addr = 0 -> disp_dout = 0x7FF one cycle later; with scroll_din = 59, disp_addr = 160 -> reads phys 80 (wrap-around).
REQ-029 clr_start with clr_val = 0x020 -> busy high for exactly 4800 cycles; afterwards, reads of addrs 0, 2399 and 4799 return 0x020; a cpu_we during busy has no effect.
REQ-030 Reset at cycle 100 of a clear -> busy = 0 immediately; addrs 0..98 = fill value, addr 4000 unchanged.
REQ-031 Same-cycle write 0x011 over 0x022 at addr 7 with display read of addr 7 -> disp_dout = 0x022, and the next display read returns 0x011.
REQ-032 disp_rdn = 1 -> disp_dout = 0; scroll_din = 60 -> scroll_row unchanged.
